// File: rtl/fir_tap_sequencer.sv
// Tap sequencer for a time-multiplexed FIR MAC: keeps the last CHAIN_DEPTH samples
// in a circular buffer and replays x[n], x[n-1], ... one tap per beat.
module fir_tap_sequencer #(
    parameter int DATA_WIDTH  = 16,
    parameter int CHAIN_DEPTH = 53,
    parameter int IDX_WIDTH   = $clog2(CHAIN_DEPTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic        [IDX_WIDTH-1:0]  out_idx,
    output logic                         out_last,
    output logic                         busy
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(CHAIN_DEPTH - 1);
    localparam logic [IDX_WIDTH-1:0] DEPTH_W   = IDX_WIDTH'(CHAIN_DEPTH);
    localparam logic [IDX_WIDTH-1:0] IDX_ZERO  = {IDX_WIDTH{1'b0}};
    localparam logic [IDX_WIDTH-1:0] IDX_ONE   = IDX_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    state_t                        state;
    state_t                        next_state;
    logic signed [DATA_WIDTH-1:0]  mem [CHAIN_DEPTH];
    logic        [IDX_WIDTH-1:0]   wptr;
    logic        [IDX_WIDTH-1:0]   base;
    logic        [IDX_WIDTH-1:0]   k;
    logic        [IDX_WIDTH-1:0]   rd_addr;
    logic                          accept;
    logic                          beat_done;
    logic                          at_last;

    assign accept    = (state == IDLE) && in_valid;
    assign beat_done = (state == STREAM) && out_ready;
    assign at_last   = (k == LAST_IDX);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    next_state = STREAM;
                end else begin
                    next_state = IDLE;
                end
            end
            STREAM: begin
                if (out_ready && at_last) begin
                    next_state = IDLE;
                end else begin
                    next_state = STREAM;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // History buffer and write pointer; wptr wraps at CHAIN_DEPTH, not a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHAIN_DEPTH; i++) begin
                mem[i] <= DATA_ZERO;
            end
            wptr <= IDX_ZERO;
            base <= IDX_ZERO;
        end else if (accept) begin
            mem[wptr] <= in_data;
            base      <= wptr;
            wptr      <= (wptr == LAST_IDX) ? IDX_ZERO : wptr + IDX_ONE;
        end else begin
            wptr <= wptr;
            base <= base;
        end
    end

    // Tap counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k <= IDX_ZERO;
        end else if (accept) begin
            k <= IDX_ZERO;
        end else if (beat_done) begin
            k <= at_last ? IDX_ZERO : k + IDX_ONE;
        end else begin
            k <= k;
        end
    end

    // Read address (base - k) mod CHAIN_DEPTH; the true value is below 2**IDX_WIDTH,
    // so modular IDX_WIDTH-bit arithmetic yields it exactly.
    always_comb begin
        rd_addr = IDX_ZERO;
        if (k <= base) begin
            rd_addr = base - k;
        end else begin
            rd_addr = base - k + DEPTH_W;
        end
    end

    // Outputs depend only on registered state
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        busy      = 1'b0;
        out_data  = DATA_ZERO;
        out_idx   = IDX_ZERO;
        out_last  = 1'b0;
        case (state)
            IDLE: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
                busy      = 1'b0;
            end
            STREAM: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = mem[rd_addr];
                out_idx   = k;
                out_last  = at_last;
            end
            default: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
                busy      = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed self-checking bench for fir_tap_sequencer: a vector table of streams checked
// against a zero-initialised shift-chain model, plus wrap, stall, hold and reset sequences.
module tb_fir_tap_sequencer;

    localparam int DW = 16;
    localparam int CD = 53;
    localparam int IW = 6;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_data;
    logic        [IW-1:0] out_idx;
    logic                 out_last;
    logic                 busy;

    int n_checks = 0;
    int n_fail   = 0;
    int model [CD];

    typedef struct {
        int sample;
        bit bp;
        int exp0;
        int exp1;
        int expl;
    } vec_t;

    vec_t vecs [4];

    fir_tap_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < CD; i++) model[i] = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_in_ready"},  int'(in_ready),  1);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_data"},  int'(out_data),  0);
        chk({tag, "_out_idx"},   int'(out_idx),   0);
        chk({tag, "_out_last"},  int'(out_last),  0);
        chk({tag, "_busy"},      int'(busy),      0);
    endtask

    // Called at a negedge; offers s, waits for in_ready, returns at the negedge after the accept
    task automatic accept(input int s);
        int n = 0;
        in_valid = 1'b1;
        in_data  = DW'(s);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", int'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = CD - 1; i > 0; i--) model[i] = model[i-1];
        model[0] = s;
    endtask

    // Consumes a stream, checking each beat against the model; stops early at out_idx==abort_k
    task automatic drain(input bit bp, input int abort_k, output int d0, output int d1, output int dl);
        int   hs = 0;
        int   cyc = 0;
        bit   have_prev = 0;
        logic rdy_prev = 1'b1;
        int   pd = 0;
        int   pi = 0;
        int   pl = 0;
        d0 = -1; d1 = -1; dl = -1;
        while (hs < CD && cyc < 1000) begin
            cyc++;
            if (!out_valid) begin
                chk("beat_valid", int'(out_valid), 1);
                break;
            end
            if (abort_k >= 0 && int'(out_idx) == abort_k) return;
            if (have_prev && !rdy_prev) begin
                chk("stall_data", int'(out_data), pd);
                chk("stall_idx",  int'(out_idx),  pi);
                chk("stall_last", int'(out_last), pl);
            end
            chk("tap_idx",  int'(out_idx),  hs);
            chk("tap_data", int'(out_data), model[hs]);
            chk("tap_last", int'(out_last), (hs == CD - 1) ? 1 : 0);
            chk("tap_busy_inready", int'({busy, in_ready}), 2);
            if (hs == 0)      d0 = int'(out_data);
            if (hs == 1)      d1 = int'(out_data);
            if (hs == CD - 1) dl = int'(out_data);
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_ready) hs++;
            pd = int'(out_data);
            pi = int'(out_idx);
            pl = int'(out_last);
            rdy_prev  = out_ready;
            have_prev = 1;
            @(negedge clk);
        end
        out_ready = 1'b1;
        chk("handshakes", hs, CD);
        chk("end_in_ready",  int'(in_ready),  1);
        chk("end_out_valid", int'(out_valid), 0);
        if (!bp) chk("ready_latency", cyc + 1, CD + 1);
    endtask

    initial begin
        int d0, d1, dl;
        vecs[0] = '{sample: 100,    bp: 1'b0, exp0: 100,    exp1: 0,      expl: 0};
        vecs[1] = '{sample: -32768, bp: 1'b1, exp0: -32768, exp1: 100,    expl: 0};
        vecs[2] = '{sample: 32767,  bp: 1'b0, exp0: 32767,  exp1: -32768, expl: 0};
        vecs[3] = '{sample: -1,     bp: 1'b1, exp0: -1,     exp1: 32767,  expl: 0};

        // Reset with in_valid asserted
        reset = 1'b1; in_valid = 1'b1; in_data = 16'sd55; out_ready = 1'b1;
        model_clear();
        @(negedge clk);
        check_idle_outputs("reset");
        in_valid = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_beat_before_accept", int'(out_valid), 0);
        end

        // Vector table: successive streams share history
        for (int v = 0; v < 4; v++) begin
            accept(vecs[v].sample);
            drain(vecs[v].bp, -1, d0, d1, dl);
            chk("vec_idx0",  d0, vecs[v].exp0);
            chk("vec_idx1",  d1, vecs[v].exp1);
            chk("vec_idx52", dl, vecs[v].expl);
        end

        // Wrap: fresh history, samples 1..54
        reset = 1'b1;
        #1;
        check_idle_outputs("reset2");
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        for (int s = 1; s <= 54; s++) begin
            accept(s);
            drain(1'b0, -1, d0, d1, dl);
            if (s >= 53) begin
                chk("wrap_idx0",  d0, s);
                chk("wrap_idx1",  d1, s - 1);
                chk("wrap_idx52", dl, s - 52);
            end
        end

        // Input held during a stream
        accept(9);
        in_valid = 1'b1;
        in_data  = 16'sd5;
        drain(1'b0, -1, d0, d1, dl);
        chk("hold_s9_idx0", d0, 9);
        accept(5);
        drain(1'b0, -1, d0, d1, dl);
        chk("hold_s5_idx0", d0, 5);
        chk("hold_s5_idx1", d1, 9);

        // Reset mid-stream at k=20
        accept(11);
        drain(1'b0, 20, d0, d1, dl);
        chk("abort_at_k20", int'(out_idx), 20);
        reset = 1'b1;
        #1;
        check_idle_outputs("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        accept(7);
        drain(1'b0, -1, d0, d1, dl);
        chk("post_reset_idx0",  d0, 7);
        chk("post_reset_idx1",  d1, 0);
        chk("post_reset_idx52", dl, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
